// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a TX FIFO, runtime-selectable baud rate, parity mode and stop-bit count.
// Queued words are sent back-to-back while Tx_EN is high; the frame configuration is captured
// when a word is popped so that input changes only affect later frames.
module uart_tx_fifo_param #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic                               Clk,
  input  logic                               reset,
  input  logic [2:0]                         baud_select,
  input  logic [1:0]                         parity_mode,
  input  logic                               stop_bits,
  input  logic                               Tx_EN,
  input  logic                               Tx_WR,
  input  logic [DATA_BITS-1:0]               Tx_DATA,
  output logic                               TxD,
  output logic                               Tx_BUSY,
  output logic                               Tx_FULL,
  output logic                               Tx_EMPTY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    Tx_COUNT,
  output logic                               Tx_OVERFLOW
);

  // Rounded clock cycles per oversample tick for a given baud rate.
  function automatic int unsigned calc_div(input int unsigned baud);
    logic [63:0] den;
    logic [63:0] quo;
    den = 64'(OVERSAMPLE) * 64'(baud);
    quo = (64'(CLK_FREQ_HZ) + den / 64'd2) / den;
    return quo[31:0];
  endfunction

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned BitW   = $clog2(DATA_BITS + 1);
  localparam int unsigned OsW    = $clog2(OVERSAMPLE + 1);
  // 300 baud has the largest divisor and sizes the tick counter.
  localparam int unsigned DivMax = calc_div(300);
  localparam int unsigned DivW   = $clog2(DivMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FSM and frame state
  state_e               state_q,   state_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q,  par_en_d;
  logic                 stop2_q,   stop2_d;
  logic [2:0]           baud_q,    baud_d;
  logic [DivW-1:0]      div_cnt_q, div_cnt_d;
  logic [OsW-1:0]       os_cnt_q,  os_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 txd_q,     txd_d;

  // FIFO state
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q,  wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q,  rd_ptr_d;
  logic [CntW-1:0]      count_q,   count_d;
  logic                 full_q,    full_d;
  logic                 empty_q,   empty_d;
  logic                 ovf_q,     ovf_d;

  logic                 pop;
  logic                 push;
  logic                 start_frame;
  logic                 bit_end;
  logic [DivW-1:0]      div_lim;
  logic [DATA_BITS-1:0] head;

  assign head = mem_q[rd_ptr_q];

  // Tick divisor limit for the baud rate captured with the current frame.
  always_comb begin
    div_lim = '0;
    unique case (baud_q)
      3'd0: div_lim = DivW'(calc_div(300) - 32'd1);
      3'd1: div_lim = DivW'(calc_div(1200) - 32'd1);
      3'd2: div_lim = DivW'(calc_div(4800) - 32'd1);
      3'd3: div_lim = DivW'(calc_div(9600) - 32'd1);
      3'd4: div_lim = DivW'(calc_div(19200) - 32'd1);
      3'd5: div_lim = DivW'(calc_div(38400) - 32'd1);
      3'd6: div_lim = DivW'(calc_div(57600) - 32'd1);
      3'd7: div_lim = DivW'(calc_div(115200) - 32'd1);
      default: div_lim = '0;
    endcase
  end

  // One bit period is OVERSAMPLE ticks of div_lim+1 cycles each.
  assign bit_end = (div_cnt_q == div_lim) && (os_cnt_q == OsW'(OVERSAMPLE - 1));

  // FSM next state, baud counters, shift register and the serial bit to register.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    baud_d      = baud_q;
    div_cnt_d   = div_cnt_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    txd_d       = 1'b1;
    pop         = 1'b0;
    start_frame = 1'b0;

    if (state_q == StIdle) begin
      div_cnt_d = '0;
      os_cnt_d  = '0;
    end else if (div_cnt_q == div_lim) begin
      div_cnt_d = '0;
      os_cnt_d  = (os_cnt_q == OsW'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + OsW'(1);
    end else begin
      div_cnt_d = div_cnt_q + DivW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (Tx_EN && !empty_q) begin
          start_frame = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
            state_d   = par_en_q ? StParity : StStop;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = BitW'(1);
          end else if (Tx_EN && !empty_q) begin
            // Chain straight into the next start bit with no idle gap.
            start_frame = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      pop       = 1'b1;
      state_d   = StStart;
      shift_d   = head;
      par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d = (^head) ^ (parity_mode == 2'b10);
      stop2_d   = stop_bits;
      baud_d    = baud_select;
      div_cnt_d = '0;
      os_cnt_d  = '0;
      bit_cnt_d = '0;
    end

    // Line level follows the state one cycle later through txd_q.
    unique case (state_q)
      StIdle:   txd_d = 1'b1;
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_q[0];
      StParity: txd_d = par_bit_q;
      StStop:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy flags and overflow pulse.
  always_comb begin
    push     = Tx_WR && (!full_q || pop);
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = Tx_WR && full_q && !pop;
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= Tx_DATA;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      baud_q    <= '0;
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      baud_q    <= baud_d;
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
    end
  end

  assign TxD         = txd_q;
  assign Tx_BUSY     = (state_q != StIdle);
  assign Tx_FULL     = full_q;
  assign Tx_EMPTY    = empty_q;
  assign Tx_COUNT    = count_q;
  assign Tx_OVERFLOW = ovf_q;

endmodule
